// File: rtl/mole_board.sv
// rtl/mole_board.sv - whac-a-mole board state, per-hole lifetime timers and hit/miss judgement
//
// Parameters:
//   N_HOLES      number of holes / buttons (max 16)
//   LIFE_CYCLES  clk cycles a mole stays up before it counts as missed
//   TW           timer width, 2^TW > LIFE_CYCLES
// Ports:
//   clk                 system clock
//   reset               synchronous active-high reset; clears board and outputs
//   game_active         round running; LOW clears the board with no pulses
//   spawn_valid         spawner requests a mole this cycle
//   spawn_idx           hole index for the spawn request
//   spawn_accept        registered; HIGH one cycle after an accepted spawn
//   btn                 debounced active-high hole buttons (level)
//   mole_active         registered; bit i HIGH while a mole is up in hole i
//   miss                one-cycle pulse: wrong press or mole timeout
//   non_full_clear_hit  one-cycle pulse: correct hit, other moles remain
//   full_clear_hit      one-cycle pulse: correct hit on the last active mole
module mole_board #(
    parameter int N_HOLES     = 9,
    parameter int LIFE_CYCLES = 50_000_000,
    parameter int TW          = 26
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               game_active,
    input  logic               spawn_valid,
    input  logic [3:0]         spawn_idx,
    output logic               spawn_accept,
    input  logic [N_HOLES-1:0] btn,
    output logic [N_HOLES-1:0] mole_active,
    output logic               miss,
    output logic               non_full_clear_hit,
    output logic               full_clear_hit
);

    logic [N_HOLES-1:0] btn_prev;
    logic [TW-1:0]      timer [N_HOLES];

    logic [N_HOLES-1:0] press;
    logic [N_HOLES-1:0] press_oh;
    logic               has_press;
    logic [N_HOLES-1:0] expire;
    logic [N_HOLES-1:0] expire_adj;
    logic [N_HOLES-1:0] hit_oh;
    logic [N_HOLES-1:0] remaining;
    logic [N_HOLES-1:0] clear_mask;
    logic [N_HOLES-1:0] spawn_oh;
    logic [N_HOLES-1:0] spawn_mask;
    logic [N_HOLES-1:0] mole_next;
    logic               wrong;
    logic               hit;
    logic               miss_next;
    logic               full_next;
    logic               nonfull_next;

    always_comb begin
        press     = btn & ~btn_prev;
        press_oh  = '0;
        has_press = 1'b0;
        // Walk downwards so the lowest-index press is the one left standing.
        for (int i = N_HOLES - 1; i >= 0; i--) begin
            if (press[i]) begin
                has_press   = 1'b1;
                press_oh    = '0;
                press_oh[i] = 1'b1;
            end
        end

        expire = '0;
        for (int i = 0; i < N_HOLES; i++) begin
            expire[i] = mole_active[i] && (timer[i] == '0);
        end

        // A press landing on an expiring mole wins the tie and is a hit.
        hit_oh     = press_oh & mole_active;
        hit        = |hit_oh;
        expire_adj = expire & ~hit_oh;
        wrong      = has_press && !hit;
        miss_next  = wrong || (|expire_adj);

        // Full clear: the hit mole is the only one left once expiries are gone.
        remaining    = mole_active & ~expire_adj;
        full_next    = !miss_next && hit && (remaining == hit_oh);
        nonfull_next = !miss_next && hit && (remaining != hit_oh);

        clear_mask = expire_adj | hit_oh;

        // Out-of-range indices decode to an empty mask and are dropped.
        spawn_oh = '0;
        for (int i = 0; i < N_HOLES; i++) begin
            spawn_oh[i] = (spawn_idx == 4'(i));
        end
        spawn_mask = spawn_valid ? (spawn_oh & ~mole_active & ~clear_mask) : '0;

        mole_next = (mole_active & ~clear_mask) | spawn_mask;
    end

    always_ff @(posedge clk) begin
        btn_prev <= btn;
        if (reset || !game_active) begin
            mole_active        <= '0;
            spawn_accept       <= 1'b0;
            miss               <= 1'b0;
            non_full_clear_hit <= 1'b0;
            full_clear_hit     <= 1'b0;
            for (int i = 0; i < N_HOLES; i++) begin
                timer[i] <= '0;
            end
        end else begin
            mole_active        <= mole_next;
            spawn_accept       <= |spawn_mask;
            miss               <= miss_next;
            non_full_clear_hit <= nonfull_next;
            full_clear_hit     <= full_next;
            for (int i = 0; i < N_HOLES; i++) begin
                if (spawn_mask[i]) begin
                    timer[i] <= TW'(LIFE_CYCLES - 1);
                end else if (clear_mask[i]) begin
                    timer[i] <= '0;
                end else if (mole_active[i] && (timer[i] != '0)) begin
                    timer[i] <= timer[i] - TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mole_board.sv
// tb/tb_mole_board.sv - randomized and directed bench for mole_board against a deadline-based model
module tb_mole_board;

    localparam int N    = 9;
    localparam int LIFE = 20;
    localparam int TW   = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         game_active;
    logic         spawn_valid;
    logic [3:0]   spawn_idx;
    logic         spawn_accept;
    logic [N-1:0] btn;
    logic [N-1:0] mole_active;
    logic         miss;
    logic         non_full_clear_hit;
    logic         full_clear_hit;

    mole_board #(.N_HOLES(N), .LIFE_CYCLES(LIFE), .TW(TW)) dut (
        .clk                (clk),
        .reset              (reset),
        .game_active        (game_active),
        .spawn_valid        (spawn_valid),
        .spawn_idx          (spawn_idx),
        .spawn_accept       (spawn_accept),
        .btn                (btn),
        .mole_active        (mole_active),
        .miss               (miss),
        .non_full_clear_hit (non_full_clear_hit),
        .full_clear_hit     (full_clear_hit)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Model: each mole remembers the absolute cycle at which it times out.
    bit         m_up   [N];
    int         m_dead [N];
    bit [N-1:0] m_prev;
    int         cyc;
    bit         e_miss, e_full, e_nf, e_acc;

    function automatic bit [N-1:0] model_board();
        bit [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_up[i];
        return v;
    endfunction

    task automatic model_step();
        int  p = -1;
        bit  exp_set [N];
        bit  is_hit = 0, is_wrong = 0;
        int  n_exp = 0, n_left = 0;
        e_miss = 0; e_full = 0; e_nf = 0; e_acc = 0;
        if (reset || !game_active) begin
            for (int i = 0; i < N; i++) m_up[i] = 0;
        end else begin
            for (int i = N - 1; i >= 0; i--)
                if (btn[i] && !m_prev[i]) p = i;
            for (int i = 0; i < N; i++) exp_set[i] = m_up[i] && (cyc == m_dead[i]);
            if (p >= 0) begin
                if (m_up[p]) begin
                    is_hit = 1;
                    exp_set[p] = 0;
                end else begin
                    is_wrong = 1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (exp_set[i]) n_exp++;
                if (m_up[i] && !exp_set[i]) n_left++;
            end
            e_miss = is_wrong || (n_exp > 0);
            e_full = !e_miss && is_hit && (n_left == 1);
            e_nf   = !e_miss && is_hit && (n_left > 1);
            for (int i = 0; i < N; i++) if (exp_set[i]) m_up[i] = 0;
            if (is_hit) m_up[p] = 0;
            // Spawn legality uses the pre-update board; cleared holes were occupied anyway.
            if (spawn_valid && int'(spawn_idx) < N) begin
                if (!m_up[spawn_idx] && !exp_set[spawn_idx] && !(is_hit && p == int'(spawn_idx))
                    && !(m_up[spawn_idx])) begin
                    bit was_up = (is_hit && p == int'(spawn_idx)) || exp_set[spawn_idx];
                    if (!was_up) begin
                        m_up[spawn_idx]   = 1;
                        m_dead[spawn_idx] = cyc + LIFE;
                        e_acc = 1;
                    end
                end
            end
        end
        m_prev = btn;
        cyc++;
    endtask

    // Fixes spawn legality: a hole occupied before this cycle must reject the spawn
    // even if it gets cleared now, so capture occupancy before model_step mutates it.
    bit [N-1:0] pre_board;

    task automatic step();
        pre_board = model_board();
        if (spawn_valid && int'(spawn_idx) < N && pre_board[spawn_idx] && !(reset || !game_active)) begin
            // occupied hole: model_step must not accept; force via temporary invalid
            logic sv_save = spawn_valid;
            spawn_valid = 0;
            model_step();
            spawn_valid = sv_save;
        end else begin
            model_step();
        end
        @(posedge clk);
        #1;
        check_eq("mole_active",  32'(mole_active),        32'(model_board()));
        check_eq("miss",         32'(miss),               32'(e_miss));
        check_eq("nonfull_hit",  32'(non_full_clear_hit), 32'(e_nf));
        check_eq("full_hit",     32'(full_clear_hit),     32'(e_full));
        check_eq("spawn_accept", 32'(spawn_accept),       32'(e_acc));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic spawn(input int idx);
        spawn_valid = 1;
        spawn_idx   = 4'(idx);
        step();
        spawn_valid = 0;
    endtask

    initial begin
        int k;
        reset = 1; game_active = 0; spawn_valid = 0; spawn_idx = 0; btn = '0;
        cyc = 0; m_prev = '0;
        for (int i = 0; i < N; i++) begin m_up[i] = 0; m_dead[i] = 0; end
        #1;
        step();
        check_eq("reset_board", 32'(mole_active), 32'h0);
        reset = 0; game_active = 1;
        idle(2);

        // Single mole hit after 5 cycles -> full clear one cycle after the edge.
        spawn(3);
        idle(5);
        btn[3] = 1;
        step();
        check_eq("s1_full_pulse", 32'(full_clear_hit), 32'h1);
        check_eq("s1_board", 32'(mole_active), 32'h0);
        step();
        check_eq("s1_full_once", 32'(full_clear_hit), 32'h0);
        btn = '0;
        step();

        // Two moles, hit one -> non-full clear; holding the button gives nothing more.
        spawn(1);
        spawn(4);
        btn[1] = 1;
        step();
        check_eq("s2_nf_pulse", 32'(non_full_clear_hit), 32'h1);
        check_eq("s2_board", 32'(mole_active), 32'h010);
        idle(4);
        check_eq("s2_hold_quiet", 32'(non_full_clear_hit | miss), 32'h0);
        btn = '0;
        game_active = 0;
        step();
        game_active = 1;
        step();

        // Press on an empty board -> miss.
        btn[7] = 1;
        step();
        check_eq("s3_miss", 32'(miss), 32'h1);
        check_eq("s3_board", 32'(mole_active), 32'h0);
        btn = '0;
        step();

        // Timeout exactly LIFE cycles after spawn_accept.
        spawn(2);
        check_eq("s4_accept", 32'(spawn_accept), 32'h1);
        k = 0;
        while (k < 2 * LIFE + 5) begin
            k++;
            step();
            if (miss) break;
        end
        check_eq("s4_timeout_cycles", 32'(k), 32'(LIFE));
        check_eq("s4_board", 32'(mole_active), 32'h0);

        // Illegal spawns and simultaneous presses.
        spawn(5);
        spawn(5);
        check_eq("s5_occupied_drop", 32'(spawn_accept), 32'h0);
        spawn(12);
        check_eq("s5_range_drop", 32'(spawn_accept), 32'h0);
        btn[0] = 1; btn[5] = 1;
        step();
        check_eq("s5_low_idx_miss", 32'(miss), 32'h1);
        check_eq("s5_mole5_up", 32'(mole_active[5]), 32'h1);
        btn = '0;
        step();

        // Reset mid-round with a held button.
        spawn(0);
        spawn(6);
        btn[2] = 1;
        reset = 1;
        step();
        check_eq("s6_reset_board", 32'(mole_active), 32'h0);
        check_eq("s6_reset_pulses", 32'({miss, non_full_clear_hit, full_clear_hit, spawn_accept}), 32'h0);
        reset = 0;
        idle(3);
        check_eq("s6_held_no_pulse", 32'(miss), 32'h0);
        btn = '0;
        step();

        // Randomized phase.
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 299) == 0);
            game_active = ($urandom_range(0, 199) != 0);
            spawn_valid = ($urandom_range(0, 3) == 0);
            spawn_idx   = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 19) == 0) btn[i] = ~btn[i];
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
